// File: rtl/alu_nibble_sequencer.sv
// Nibble-serial controller for one external 4-bit '181-style ALU slice: WIDTH-bit ops, LSB nibble first.
// Optional registered A=B flag output (aeqb) when ALU_NIBBLE_SEQUENCER_AEQB_EN is defined.
module alu_nibble_sequencer #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op_s,
    input  logic             op_m,
    input  logic             cin_n,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout_n,
    output logic             zero,
    output logic [3:0]       slc_a,
    output logic [3:0]       slc_b,
    output logic [3:0]       slc_s,
    output logic             slc_m,
    output logic             slc_ci,
    input  logic [3:0]       slc_f,
    input  logic             slc_co
`ifdef ALU_NIBBLE_SEQUENCER_AEQB_EN
    ,
    output logic             aeqb
`endif
);

    localparam int unsigned NIBBLES = WIDTH / 4;
    localparam int unsigned IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             load;
    logic             capture;
    logic             last;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [3:0]       s_reg;
    logic             m_reg;
    logic             carry;
    logic [WIDTH-1:0] result_next;

    assign last = (idx == IDX_W'(NIBBLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A start is accepted in DONE as well as IDLE, which gives back-to-back operation.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                capture = 1'b1;
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy   = (state == RUN);
    assign done   = (state == DONE);
    assign slc_a  = capture ? a_reg[{idx, 2'b00} +: 4] : '0;
    assign slc_b  = capture ? b_reg[{idx, 2'b00} +: 4] : '0;
    assign slc_s  = s_reg;
    assign slc_m  = m_reg;
    assign slc_ci = carry;

    // Full result including the nibble being captured, so zero is valid in the done cycle.
    always_comb begin
        result_next = result;
        result_next[{idx, 2'b00} +: 4] = slc_f;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx    <= '0;
            a_reg  <= '0;
            b_reg  <= '0;
            s_reg  <= '0;
            m_reg  <= 1'b0;
            carry  <= 1'b1;
            result <= '0;
            cout_n <= 1'b1;
            zero   <= 1'b1;
        end else if (load) begin
            idx    <= '0;
            a_reg  <= a_in;
            b_reg  <= b_in;
            s_reg  <= op_s;
            m_reg  <= op_m;
            carry  <= cin_n;
        end else if (capture) begin
            result <= result_next;
            carry  <= slc_co;
            idx    <= last ? '0 : idx + IDX_W'(1);
            if (last) begin
                cout_n <= m_reg ? 1'b1 : slc_co;
                zero   <= (result_next == '0);
            end
        end
    end

`ifdef ALU_NIBBLE_SEQUENCER_AEQB_EN
    logic all_f;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            all_f <= 1'b1;
            aeqb  <= 1'b0;
        end else if (load) begin
            all_f <= 1'b1;
        end else if (capture) begin
            all_f <= all_f & (slc_f == 4'hF);
            if (last) begin
                aeqb <= all_f & (slc_f == 4'hF);
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Self-checking bench: behavioural '181 slice on the slc_* ports plus a scoreboard of whole-word expectations.
// Build with ALU_NIBBLE_SEQUENCER_AEQB_EN defined to also check aeqb.
module tb_alu_nibble_sequencer;

    localparam int unsigned WIDTH = 16;
    localparam int          NIB   = WIDTH / 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [3:0]       op_s;
    logic             op_m;
    logic             cin_n;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout_n;
    logic             zero;
    logic [3:0]       slc_a;
    logic [3:0]       slc_b;
    logic [3:0]       slc_s;
    logic             slc_m;
    logic             slc_ci;
    logic [3:0]       slc_f;
    logic             slc_co;
`ifdef ALU_NIBBLE_SEQUENCER_AEQB_EN
    logic             aeqb;
`endif

    alu_nibble_sequencer #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op_s   (op_s),
        .op_m   (op_m),
        .cin_n  (cin_n),
        .a_in   (a_in),
        .b_in   (b_in),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout_n (cout_n),
        .zero   (zero),
        .slc_a  (slc_a),
        .slc_b  (slc_b),
        .slc_s  (slc_s),
        .slc_m  (slc_m),
        .slc_ci (slc_ci),
        .slc_f  (slc_f),
        .slc_co (slc_co)
`ifdef ALU_NIBBLE_SEQUENCER_AEQB_EN
        ,
        .aeqb   (aeqb)
`endif
    );

    always #5 clk = ~clk;

    // '181 with active-high data: arithmetic is F = X + Y + ~Cn, Cn+4 = ~carry.
    function automatic logic [4:0] slice_fn(input logic [3:0] a, input logic [3:0] b,
                                            input logic [3:0] s, input logic m, input logic cn);
        logic [3:0] x;
        logic [3:0] y;
        logic [3:0] lf;
        logic [4:0] sum;
        x  = a;
        y  = 4'h0;
        lf = 4'h0;
        if (m) begin
            case (s)
                4'h0: lf = ~a;        4'h1: lf = ~(a | b);
                4'h2: lf = ~a & b;    4'h3: lf = 4'h0;
                4'h4: lf = ~(a & b);  4'h5: lf = ~b;
                4'h6: lf = a ^ b;     4'h7: lf = a & ~b;
                4'h8: lf = ~a | b;    4'h9: lf = ~(a ^ b);
                4'hA: lf = b;         4'hB: lf = a & b;
                4'hC: lf = 4'hF;      4'hD: lf = a | ~b;
                4'hE: lf = a | b;     default: lf = a;
            endcase
            return {1'b1, lf};
        end
        case (s)
            4'h0: begin x = a;      y = 4'h0;   end
            4'h1: begin x = a | b;  y = 4'h0;   end
            4'h2: begin x = a | ~b; y = 4'h0;   end
            4'h3: begin x = 4'h0;   y = 4'hF;   end
            4'h4: begin x = a;      y = a & ~b; end
            4'h5: begin x = a | b;  y = a & ~b; end
            4'h6: begin x = a;      y = ~b;     end
            4'h7: begin x = a & ~b; y = 4'hF;   end
            4'h8: begin x = a;      y = a & b;  end
            4'h9: begin x = a;      y = b;      end
            4'hA: begin x = a | ~b; y = a & b;  end
            4'hB: begin x = a & b;  y = 4'hF;   end
            4'hC: begin x = a;      y = a;      end
            4'hD: begin x = a | b;  y = a;      end
            4'hE: begin x = a | ~b; y = a;      end
            default: begin x = a;   y = 4'hF;   end
        endcase
        sum = {1'b0, x} + {1'b0, y} + {4'b0, ~cn};
        return {~sum[4], sum[3:0]};
    endfunction

    always_comb begin
        {slc_co, slc_f} = slice_fn(slc_a, slc_b, slc_s, slc_m, slc_ci);
    end

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             co;
        logic             z;
        logic             eq;
    } exp_t;

    function automatic exp_t ref_op(input logic [3:0] s, input logic m, input logic cn,
                                    input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t       r;
        logic       c;
        logic [4:0] o;
        c     = cn;
        r.res = '0;
        r.eq  = 1'b1;
        for (int k = 0; k < NIB; k++) begin
            o = slice_fn(a[4*k +: 4], b[4*k +: 4], s, m, c);
            r.res[4*k +: 4] = o[3:0];
            r.eq = r.eq & (o[3:0] == 4'hF);
            c = o[4];
        end
        r.co = m ? 1'b1 : c;
        r.z  = (r.res == '0);
        return r;
    endfunction

    exp_t       sbq[$];
    exp_t       e;
    int         checks = 0;
    int         errors = 0;
    int         lat;
    int         busy_cnt;
    logic [7:0] ci_seen;

    // Called while the DUT is in IDLE or DONE; returns #1 after the start edge.
    task automatic drive_start(input logic [3:0] s, input logic m, input logic cn,
                               input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        op_s  = s;
        op_m  = m;
        cin_n = cn;
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        sbq.push_back(ref_op(s, m, cn, a, b));
        @(posedge clk);
        #1;
        start = 1'b0;
        a_in  = WIDTH'($urandom);
        b_in  = WIDTH'($urandom);
        op_s  = 4'($urandom);
        op_m  = 1'($urandom);
        cin_n = 1'($urandom);
    endtask

    // lat = clock edges after the start edge until done is seen; bounded.
    task automatic wait_done();
        lat      = 0;
        busy_cnt = 0;
        ci_seen  = '0;
        while (done !== 1'b1 && lat < 20) begin
            if (busy === 1'b1 && busy_cnt < 8) begin
                ci_seen[busy_cnt] = slc_ci;
                busy_cnt++;
            end
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        op_s  = '0;
        op_m  = 1'b0;
        cin_n = 1'b1;
        a_in  = '0;
        b_in  = '0;
        #12;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (result !== '0) begin errors++; $display("FAIL reset_result: got %h expected 0", result); end
        checks++; if (cout_n !== 1'b1 || zero !== 1'b1) begin errors++; $display("FAIL reset_flags: got cout_n=%b zero=%b expected 1 1", cout_n, zero); end
        checks++; if (slc_a !== 4'h0 || slc_b !== 4'h0 || slc_ci !== 1'b1) begin errors++; $display("FAIL reset_slice: got a=%h b=%h ci=%b expected 0 0 1", slc_a, slc_b, slc_ci); end
`ifdef ALU_NIBBLE_SEQUENCER_AEQB_EN
        checks++; if (aeqb !== 1'b0) begin errors++; $display("FAIL reset_aeqb: got %b expected 0", aeqb); end
`endif
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_add();
        drive_start(4'b1001, 1'b0, 1'b1, 16'h1234, 16'h0001);
        wait_done();
        e = sbq.pop_front();
        checks++; if (lat !== NIB) begin errors++; $display("FAIL add_latency: got %0d expected %0d", lat, NIB); end
        checks++; if (busy_cnt !== NIB) begin errors++; $display("FAIL add_busy_cycles: got %0d expected %0d", busy_cnt, NIB); end
        checks++; if (result !== e.res || result !== 16'h1235) begin errors++; $display("FAIL add_result: got %h expected 1235", result); end
        checks++; if (cout_n !== 1'b1 || zero !== 1'b0) begin errors++; $display("FAIL add_flags: got cout_n=%b zero=%b expected 1 0", cout_n, zero); end
        @(posedge clk);
        #1;
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL add_done_pulse: got done=%b busy=%b expected 0 0", done, busy); end
        checks++; if (result !== 16'h1235) begin errors++; $display("FAIL add_result_hold: got %h expected 1235", result); end
    endtask

    task automatic test_carry_ripple();
        drive_start(4'b1001, 1'b0, 1'b1, 16'hFFFF, 16'h0001);
        wait_done();
        e = sbq.pop_front();
        checks++; if (ci_seen[3:0] !== 4'b0001) begin errors++; $display("FAIL ripple_ci: got %b expected 0001 (nibble0 in lsb)", ci_seen[3:0]); end
        checks++; if (result !== e.res || result !== 16'h0000) begin errors++; $display("FAIL ripple_result: got %h expected 0000", result); end
        checks++; if (cout_n !== 1'b0 || zero !== 1'b1) begin errors++; $display("FAIL ripple_flags: got cout_n=%b zero=%b expected 0 1", cout_n, zero); end
    endtask

    task automatic test_sub();
        drive_start(4'b0110, 1'b0, 1'b0, 16'h0005, 16'h0003);
        wait_done();
        e = sbq.pop_front();
        checks++; if (result !== e.res || result !== 16'h0002) begin errors++; $display("FAIL sub1_result: got %h expected 0002", result); end
        checks++; if (cout_n !== 1'b0 || zero !== 1'b0) begin errors++; $display("FAIL sub1_flags: got cout_n=%b zero=%b expected 0 0", cout_n, zero); end
        drive_start(4'b0110, 1'b0, 1'b0, 16'h0003, 16'h0005);
        wait_done();
        e = sbq.pop_front();
        checks++; if (result !== e.res || result !== 16'hFFFE) begin errors++; $display("FAIL sub2_result: got %h expected fffe", result); end
        checks++; if (cout_n !== 1'b1) begin errors++; $display("FAIL sub2_cout: got %b expected 1", cout_n); end
    endtask

    task automatic test_back_to_back();
        drive_start(4'b0110, 1'b1, 1'b1, 16'hA5A5, 16'hFFFF);
        wait_done();
        e = sbq.pop_front();
        checks++; if (result !== e.res || result !== 16'h5A5A) begin errors++; $display("FAIL xor_result: got %h expected 5a5a", result); end
        checks++; if (cout_n !== 1'b1 || zero !== 1'b0) begin errors++; $display("FAIL xor_flags: got cout_n=%b zero=%b expected 1 0", cout_n, zero); end
        drive_start(4'b1001, 1'b0, 1'b1, 16'h0001, 16'h0001);
        wait_done();
        e = sbq.pop_front();
        checks++; if (lat !== NIB) begin errors++; $display("FAIL b2b_latency: got %0d expected %0d", lat, NIB); end
        checks++; if (result !== e.res || result !== 16'h0002) begin errors++; $display("FAIL b2b_result: got %h expected 0002", result); end
    endtask

    task automatic test_ignore_start();
        drive_start(4'b1001, 1'b0, 1'b1, 16'h0100, 16'h0020);
        start = 1'b1;
        op_s  = 4'b0000;
        op_m  = 1'b1;
        a_in  = 16'hFFFF;
        b_in  = 16'hFFFF;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done();
        e = sbq.pop_front();
        checks++; if (lat + 1 !== NIB) begin errors++; $display("FAIL ignore_latency: got %0d expected %0d", lat + 1, NIB); end
        checks++; if (result !== e.res || result !== 16'h0120) begin errors++; $display("FAIL ignore_result: got %h expected 0120", result); end
        @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL ignore_no_second_op: got busy=%b done=%b expected 0 0", busy, done); end
    endtask

    task automatic test_reset_mid_op();
        logic saw_done;
        drive_start(4'b0110, 1'b0, 1'b0, 16'h0005, 16'h0003);
        wait_done();
        e = sbq.pop_front();
        checks++; if (result !== 16'h0002 || cout_n !== 1'b0) begin errors++; $display("FAIL premid_state: got result=%h cout_n=%b expected 0002 0", result, cout_n); end
        drive_start(4'b1001, 1'b0, 1'b1, 16'h1111, 16'h2222);
        e = sbq.pop_front();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mid_reset_busy: got busy=%b done=%b expected 0 0", busy, done); end
        checks++; if (result !== '0 || zero !== 1'b1 || cout_n !== 1'b1) begin errors++; $display("FAIL mid_reset_regs: got result=%h zero=%b cout_n=%b expected 0000 1 1", result, zero, cout_n); end
        #2;
        reset = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) saw_done = 1'b1;
        end
        checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL mid_reset_no_done: got done pulse expected none"); end
        drive_start(4'b1001, 1'b0, 1'b1, 16'h0F0F, 16'h0101);
        wait_done();
        e = sbq.pop_front();
        checks++; if (lat !== NIB || result !== e.res || result !== 16'h1010) begin errors++; $display("FAIL post_reset_op: got lat=%0d result=%h expected %0d 1010", lat, result, NIB); end
    endtask

    task automatic test_aeqb();
        drive_start(4'b0110, 1'b0, 1'b1, 16'h3C3C, 16'h3C3C);
        wait_done();
        e = sbq.pop_front();
        checks++; if (result !== e.res || result !== 16'hFFFF) begin errors++; $display("FAIL aeqb1_result: got %h expected ffff", result); end
`ifdef ALU_NIBBLE_SEQUENCER_AEQB_EN
        checks++; if (aeqb !== 1'b1 || aeqb !== e.eq) begin errors++; $display("FAIL aeqb1_flag: got %b expected 1", aeqb); end
`endif
        drive_start(4'b0110, 1'b0, 1'b1, 16'h3C3C, 16'h3C3D);
        wait_done();
        e = sbq.pop_front();
        checks++; if (result !== e.res || result !== 16'hFFFE) begin errors++; $display("FAIL aeqb2_result: got %h expected fffe", result); end
`ifdef ALU_NIBBLE_SEQUENCER_AEQB_EN
        checks++; if (aeqb !== 1'b0) begin errors++; $display("FAIL aeqb2_flag: got %b expected 0", aeqb); end
`endif
    endtask

    task automatic test_random_ops();
        for (int i = 0; i < 12; i++) begin
            drive_start(4'($urandom), 1'($urandom), 1'($urandom), WIDTH'($urandom), WIDTH'($urandom));
            wait_done();
            e = sbq.pop_front();
            checks++; if (lat !== NIB || result !== e.res) begin errors++; $display("FAIL rand%0d_result: got lat=%0d result=%h expected %0d %h", i, lat, result, NIB, e.res); end
            checks++; if (cout_n !== e.co || zero !== e.z) begin errors++; $display("FAIL rand%0d_flags: got cout_n=%b zero=%b expected %b %b", i, cout_n, zero, e.co, e.z); end
`ifdef ALU_NIBBLE_SEQUENCER_AEQB_EN
            checks++; if (aeqb !== e.eq) begin errors++; $display("FAIL rand%0d_aeqb: got %b expected %b", i, aeqb, e.eq); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_carry_ripple();
        test_sub();
        test_back_to_back();
        test_ignore_start();
        test_reset_mid_op();
        test_aeqb();
        test_random_ops();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
